// File: rtl/tmon_sensor_ctrl.sv
// rtl/tmon_sensor_ctrl.sv - temperature sensor sequencer (op decode, periodic sampling, alert/timeout); TMON_HYST_EN adds alert-clear hysteresis
module tmon_sensor_ctrl #(
    parameter logic [7:0] DEF_FRQ  = 8'd100,
    parameter logic [7:0] DEF_HIGH = 8'd80,
    parameter int         TMO      = 16,
    parameter int         HYST     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [7:0] opnd,
    input  logic       valid,
    output logic       ready,
    output logic       ack,
    output logic       smp_req,
    input  logic       smp_valid,
    input  logic [7:0] smp_data,
    output logic [7:0] temp,
    output logic       alert,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SAMPLE
    } state_t;

    localparam logic [1:0] OP_RESET    = 2'd1;
    localparam logic [1:0] OP_SET_FRQ  = 2'd2;
    localparam logic [1:0] OP_SET_HIGH = 2'd3;

    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

`ifdef TMON_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    // Clear test is data + band < high + slack: with hysteresis that is data < high-HYST
    // (never true once high-HYST saturates at 0), without it data <= high.
    localparam logic [9:0] CLR_BAND  = HYST_ON ? 10'(HYST) : 10'd0;
    localparam logic [9:0] CLR_SLACK = HYST_ON ? 10'd0 : 10'd1;

    state_t          state;
    logic [7:0]      frq;
    logic [7:0]      high;
    logic [7:0]      cnt;
    logic            pending;
    logic [TW-1:0]   tmo_cnt;
    logic [1:0]      op_q;
    logic [7:0]      opnd_q;

    logic tick;
    logic accept;
    logic over_high;
    logic under_clr;

    assign tick      = (frq != 8'd0) && (cnt == 8'd1);
    assign accept    = (state == IDLE) && valid && ready;
    assign over_high = smp_data > high;
    assign under_clr = ({2'b00, smp_data} + CLR_BAND) < ({2'b00, high} + CLR_SLACK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ready   <= 1'b0;
            ack     <= 1'b0;
            smp_req <= 1'b0;
            temp    <= 8'd0;
            alert   <= 1'b0;
            err     <= 1'b0;
            pending <= 1'b0;
            frq     <= DEF_FRQ;
            high    <= DEF_HIGH;
            cnt     <= DEF_FRQ;
            tmo_cnt <= '0;
            op_q    <= 2'd0;
            opnd_q  <= 8'd0;
        end else begin
            ack <= 1'b0;

            if (frq != 8'd0) begin
                cnt <= tick ? frq : cnt - 8'd1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        opnd_q <= opnd;
                        ack    <= 1'b1;
                        ready  <= 1'b0;
                        state  <= EXEC;
                        if (tick) begin
                            pending <= 1'b1;
                        end
                    end else if (tick || pending) begin
                        pending <= 1'b0;
                        tmo_cnt <= '0;
                        smp_req <= 1'b1;
                        ready   <= 1'b0;
                        state   <= SAMPLE;
                    end else begin
                        ready <= 1'b1;
                    end
                end

                EXEC: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    if (tick) begin
                        pending <= 1'b1;
                    end
                    // Later assignments here override the counter and pending updates above.
                    case (op_q)
                        OP_RESET: begin
                            frq     <= DEF_FRQ;
                            high    <= DEF_HIGH;
                            cnt     <= DEF_FRQ;
                            temp    <= 8'd0;
                            alert   <= 1'b0;
                            err     <= 1'b0;
                            pending <= 1'b0;
                        end
                        OP_SET_FRQ: begin
                            frq <= opnd_q;
                            cnt <= opnd_q;
                        end
                        OP_SET_HIGH: begin
                            high <= opnd_q;
                        end
                        default: begin
                        end
                    endcase
                end

                SAMPLE: begin
                    if (tick) begin
                        pending <= 1'b1;
                    end
                    if (smp_valid) begin
                        temp <= smp_data;
                        if (over_high) begin
                            alert <= 1'b1;
                        end else if (under_clr) begin
                            alert <= 1'b0;
                        end
                        smp_req <= 1'b0;
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err     <= 1'b1;
                        smp_req <= 1'b0;
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    ready   <= 1'b0;
                    smp_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmon_sensor_ctrl.sv
// tb/tb_tmon_sensor_ctrl.sv - self-checking bench for tmon_sensor_ctrl
module tb_tmon_sensor_ctrl;

    localparam int DEF_FRQ  = 100;
    localparam int DEF_HIGH = 80;
    localparam int TMO      = 16;
    localparam int HYST     = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] op = 2'd0;
    logic [7:0] opnd = 8'd0;
    logic       valid = 1'b0;
    logic       ready;
    logic       ack;
    logic       smp_req;
    logic       smp_valid = 1'b0;
    logic [7:0] smp_data = 8'd0;
    logic [7:0] temp;
    logic       alert;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    int m_frq  = DEF_FRQ;
    int m_high = DEF_HIGH;
    int m_temp = 0;
    bit m_alert = 1'b0;
    bit m_err = 1'b0;

    tmon_sensor_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .opnd     (opnd),
        .valid    (valid),
        .ready    (ready),
        .ack      (ack),
        .smp_req  (smp_req),
        .smp_valid(smp_valid),
        .smp_data (smp_data),
        .temp     (temp),
        .alert    (alert),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit alert_ref(input bit cur, input int d, input int h);
        int lim;
        lim = h - HYST;
        if (lim < 0) lim = 0;
        if (d > h) return 1'b1;
`ifdef TMON_HYST_EN
        if (d < lim) return 1'b0;
        return cur;
`else
        return (d <= h) ? 1'b0 : cur;
`endif
    endfunction

    task automatic wait_req(input int limit, output int waited);
        waited = 0;
        while (smp_req !== 1'b1 && waited < limit) begin
            step();
            waited++;
        end
        chk("req_seen", smp_req, 1);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [7:0] d);
        int w;
        w = 0;
        op = o;
        opnd = d;
        valid = 1'b1;
        while (ready !== 1'b1 && w < 200) begin
            step();
            w++;
        end
        chk("op_ready", ready, 1);
        step();
        chk("ack_pulse", ack, 1);
        chk("ready_exec", ready, 0);
        valid = 1'b0;
        step();
        chk("ack_drop", ack, 0);
        case (o)
            2'd1: begin
                m_frq = DEF_FRQ; m_high = DEF_HIGH; m_temp = 0; m_alert = 1'b0; m_err = 1'b0;
            end
            2'd2: m_frq = int'(d);
            2'd3: m_high = int'(d);
            default: ;
        endcase
    endtask

    task automatic serve(input int d, input int dly);
        int w;
        wait_req(300, w);
        repeat (dly) step();
        chk("req_held", smp_req, 1);
        smp_valid = 1'b1;
        smp_data = 8'(d);
        step();
        smp_valid = 1'b0;
        m_temp = d;
        m_alert = alert_ref(m_alert, d, m_high);
        chk("req_drop", smp_req, 0);
        chk("ready_after_cap", ready, 1);
        chk("temp_cap", temp, m_temp);
        chk("alert_cap", alert, m_alert);
        chk("err_cap", err, m_err);
    endtask

    initial begin
        int w;
        int n;
        int sel;
        int dd;
        bit exp80;

        #1 reset = 1'b0;
        #2;
        chk("rst_ready", ready, 0);
        chk("rst_ack", ack, 0);
        chk("rst_req", smp_req, 0);
        chk("rst_temp", temp, 0);
        chk("rst_alert", alert, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        chk("ready_pre_edge", ready, 0);
        step();
        chk("ready_rise", ready, 1);

        // Period 5: first request five cycles after the op lands, then every five cycles.
        do_op(2'd2, 8'd5);
        wait_req(300, w);
        chk("first_tick", w, m_frq);
        serve(60, 0);
        wait_req(300, w);
        chk("tick_period", w, m_frq - 1);
        serve(70, 0);

        for (int i = 0; i < 14; i++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                do_op(2'd0, 8'($urandom));
            end else if (sel == 1) begin
                do_op(2'd3, 8'($urandom_range(20, 230)));
            end
            chk("alert_hold", alert, m_alert);
            chk("temp_hold", temp, m_temp);
            dd = m_high + int'($urandom_range(0, 8)) - 4;
            if (dd < 0) dd = 0;
            if (dd > 255) dd = 255;
            serve(dd, int'($urandom_range(0, 10)));
        end

        do_op(2'd3, 8'd80);
        serve(81, 0);
        chk("alert_81", alert, 1);
`ifdef TMON_HYST_EN
        exp80 = 1'b1;
`else
        exp80 = 1'b0;
`endif
        serve(80, 1);
        chk("alert_80", alert, exp80);
        serve(77, 2);
        chk("alert_77", alert, 0);

        // Silent sensor: timeout, sticky err, stray smp_valid outside SAMPLE.
        wait_req(300, w);
        n = 0;
        while (smp_req === 1'b1 && n < 40) begin
            step();
            n++;
        end
        m_err = 1'b1;
        chk("tmo_len", n, TMO);
        chk("tmo_err", err, 1);
        chk("tmo_temp", temp, m_temp);
        smp_valid = 1'b1;
        smp_data = 8'd200;
        step();
        smp_valid = 1'b0;
        chk("stray_valid", temp, m_temp);
        serve(55, 0);
        chk("err_sticky", err, 1);
        do_op(2'd1, 8'd0);
        chk("rstop_err", err, 0);
        chk("rstop_temp", temp, 0);
        chk("rstop_alert", alert, 0);
        wait_req(300, w);
        chk("rstop_frq", w, DEF_FRQ);
        serve(81, 3);
        chk("rstop_high", alert, 1);

        // Op held across a sample; tick during the sample is serviced after the ack.
        do_op(2'd2, 8'd5);
        wait_req(300, w);
        op = 2'd3;
        opnd = 8'd90;
        valid = 1'b1;
        repeat (7) step();
        chk("held_ready", ready, 0);
        chk("held_req", smp_req, 1);
        smp_valid = 1'b1;
        smp_data = 8'd85;
        step();
        smp_valid = 1'b0;
        m_temp = 85;
        m_alert = alert_ref(m_alert, 85, m_high);
        chk("held_cap_temp", temp, m_temp);
        chk("held_cap_ready", ready, 1);
        chk("held_cap_req", smp_req, 0);
        step();
        chk("held_ack", ack, 1);
        valid = 1'b0;
        m_high = 90;
        step();
        chk("held_ack_drop", ack, 0);
        chk("held_idle_req", smp_req, 0);
        step();
        chk("pending_serviced", smp_req, 1);
        serve(88, 0);

        // Hardware reset mid-sample with an op waiting.
        wait_req(300, w);
        op = 2'd2;
        opnd = 8'd9;
        valid = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk("async_req", smp_req, 0);
        chk("async_ready", ready, 0);
        chk("async_ack", ack, 0);
        chk("async_temp", temp, 0);
        chk("async_alert", alert, 0);
        chk("async_err", err, 0);
        valid = 1'b0;
        m_frq = DEF_FRQ; m_high = DEF_HIGH; m_temp = 0; m_alert = 1'b0; m_err = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        chk("rerst_ready", ready, 1);
        chk("rerst_ack", ack, 0);
        wait_req(300, w);
        chk("rerst_frq", w, DEF_FRQ - 1);
        serve(81, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tmon_sensor_ctrl.md
TMON_SENSOR_CTRL -- requirements
Module: tmon_sensor_ctrl

Interface
REQ-001 Parameter DEF_FRQ, 8'd100, sample period in clk cycles after reset.
REQ-002 Parameter DEF_HIGH, 8'd80, high-temperature threshold after reset.
REQ-003 Parameter TMO, 16, cycles allowed for sensor response before timeout.
REQ-004 Parameter HYST, 2, alert-clear hysteresis in degrees (used only with TMON_HYST_EN).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 op  in  2  opcode from upstream tmon_master: 0 NOOP, 1 RESET, 2 SET_FRQ, 3 SET_HIGH_TEMP.
REQ-008 opnd  in  8  operand for SET_FRQ / SET_HIGH_TEMP.
REQ-009 valid  in  1  op/opnd valid; held by master until accepted.
REQ-010 ready  out  1  block can accept an op this cycle.
REQ-011 ack  out  1  one-cycle pulse: accepted op has been applied.
REQ-012 smp_req  out  1  request a conversion from the sensor.
REQ-013 smp_valid  in  1  sensor data valid.
REQ-014 smp_data  in  8  unsigned sensor reading.
REQ-015 temp  out  8  last captured reading.
REQ-016 alert  out  1  over-temperature flag.
REQ-017 err  out  1  sticky sensor-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, SAMPLE; SAMPLE is left via capture or timeout.
REQ-019 ready SHALL be registered, 1 only in IDLE; op accepted on the edge where valid && ready.
REQ-020 Acceptance SHALL move IDLE->EXEC; in EXEC the op is applied, ack=1 for exactly that cycle, ready=0; next state IDLE.
REQ-021 Max op throughput SHALL be one op per 2 cycles.
REQ-022 NOOP: ack only, no state change.
REQ-023 SET_FRQ: frq<=opnd, period counter reloaded with opnd; opnd 0 disables sampling.
REQ-024 SET_HIGH_TEMP: high<=opnd; alert unchanged until next capture.
REQ-025 RESET op: frq, high, temp, alert, err, counter restored to reset values; ack still pulses.
REQ-026 Period counter SHALL decrement each cycle while frq!=0 and raise a tick when it reaches 1, reloading frq.
REQ-027 Tick in IDLE with no valid SHALL move IDLE->SAMPLE; tick in EXEC/SAMPLE, or coinciding with acceptance, SHALL set a pending flag serviced on the next IDLE cycle; op acceptance has priority over pending tick.
REQ-028 Multiple ticks while pending SHALL collapse into one sample.
REQ-029 smp_req SHALL be 1 for every SAMPLE cycle and drop the cycle after capture or timeout.
REQ-030 Capture: smp_valid in SAMPLE -> temp<=smp_data, alert set if smp_data > high (unsigned), state IDLE.
REQ-031 smp_valid outside SAMPLE SHALL be ignored.
REQ-032 Timeout: TMO cycles in SAMPLE without smp_valid -> err<=1, temp unchanged, state IDLE.
REQ-033 err SHALL clear only by RESET op or hardware reset.

Reset
REQ-034 Asserted reset SHALL immediately force: state IDLE, ready 0, ack 0, smp_req 0, temp 0, alert 0, err 0, pending 0, frq DEF_FRQ, high DEF_HIGH, counter DEF_FRQ.
REQ-035 ready SHALL rise on the first clk edge after reset deasserts.
REQ-036 Reset mid-SAMPLE or mid-EXEC SHALL abandon the operation without ack.

Configuration
REQ-037 Macro TMON_HYST_EN defined: alert clears on capture only when smp_data < high-HYST (saturating at 0).
REQ-038 TMON_HYST_EN undefined: alert clears on any capture with smp_data <= high; HYST unused.

Verification
REQ-039 Reset release -> ready=1 next edge; temp=0, alert=0, err=0, smp_req=0.
REQ-040 SET_FRQ opnd=5 -> ack one cycle after accept; smp_req asserts every 5 cycles absent stalls.
REQ-041 high=80, sensor returns 81 -> alert=1, temp=81; returns 80 -> alert=0 (no HYST) / stays 1 (HYST_EN, HYST=2); 77 -> 0.
REQ-042 Sensor silent 16 cycles -> err=1, smp_req drops, temp unchanged; RESET op -> err=0, frq=100.
REQ-043 valid held during SAMPLE -> ready=0 until capture, op accepted in following IDLE, tick arriving meanwhile serviced after ack.
REQ-044 reset asserted mid-SAMPLE -> smp_req=0 asynchronously, no ack, defaults restored.
